// File: rtl/tuner_pkg.sv
// Shared types and constants for the tuner's spectrum path.
package tuner_pkg;

  localparam int N_FFT = 512;
  localparam int BIN_W = 9;

  // One FFT result word: {re, im}, both signed Q1.15.
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } cplx_t;

  // Unsigned magnitude estimate.
  typedef logic [15:0] mag_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    FLUSH  = 2'd2,
    REPORT = 2'd3
  } peak_state_t;

  // Absolute value of a Q1.15 sample as an unsigned 16-bit value.
  // -32768 negates to the bit pattern 0x8000, which reads as 32768 unsigned.
  function automatic mag_t abs_q15(input logic signed [15:0] v);
    return v[15] ? mag_t'(-v) : mag_t'(v);
  endfunction

endpackage

// File: rtl/fft_mag_est.sv
// Two-stage alpha-max-beta-min magnitude estimator.
// Stage 1 takes |re| and |im|; stage 2 forms max + min/2.
// A valid bit and the bin index travel alongside the data.
module fft_mag_est
  import tuner_pkg::*;
#(
  parameter int ADDR_W = BIN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  cplx_t             in_data,
  input  logic [ADDR_W-1:0] in_bin,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_bin,
  output mag_t              out_mag
);

  logic              s1_valid;
  logic [ADDR_W-1:0] s1_bin;
  mag_t              s1_a;
  mag_t              s1_b;
  mag_t              mx;
  mag_t              mn;

  // Stage 1: register absolute values of both components.
  // The incoming word always belongs to the current frame, so flush does not
  // gate it; flush only kills words already inside the pipeline.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: clocked state is assigned with <= so every register samples
      // the pre-edge values of its inputs, independent of statement order.
      s1_valid <= 1'b0;
      s1_bin   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_bin   <= in_bin;
      s1_a     <= abs_q15(in_data.re);
      s1_b     <= abs_q15(in_data.im);
    end
  end

  // Select the larger and smaller of the two component magnitudes.
  always_comb begin
    // NOTE: both outputs get a value on every path, so no latch is inferred.
    mx = s1_a;
    mn = s1_b;
    if (s1_b > s1_a) begin
      mx = s1_b;
      mn = s1_a;
    end
  end

  // Stage 2: max + min/2; peaks at 0x8000 + 0x4000, so 16 bits suffice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_bin   <= '0;
      out_mag   <= '0;
    end else begin
      out_valid <= s1_valid && !flush;
      out_bin   <= s1_bin;
      out_mag   <= mx + (mn >> 1);
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming FFT post-processor: registers each result word into the output
// RAM write port and reports the strongest in-band bin once per frame.
module fft_peak_detect
  import tuner_pkg::*;
#(
  parameter int   N       = N_FFT,
  parameter int   ADDR_W  = BIN_W,
  parameter int   MIN_BIN = 1,
  parameter int   MAX_BIN = 255,
  parameter mag_t THRESH  = 16'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              res_valid,
  input  logic [31:0]       res_data,
  output logic              fft_write_en,
  output logic [ADDR_W-1:0] fft_write_addr,
  output logic [31:0]       data_from_fft,
  output logic              peak_valid,
  output logic              peak_found,
  output logic [ADDR_W-1:0] peak_bin,
  output logic [15:0]       peak_mag,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LO_BIN   = ADDR_W'(MIN_BIN);
  localparam logic [ADDR_W-1:0] HI_BIN   = ADDR_W'(MAX_BIN);

  peak_state_t       state;
  logic [ADDR_W-1:0] bin_cnt;
  logic [ADDR_W-1:0] cur_bin;
  logic [ADDR_W-1:0] next_bin;
  logic              last_bin;
  logic              frame_active;

  cplx_t             res_word;
  logic              est_valid;
  logic [ADDR_W-1:0] est_bin;
  mag_t              est_mag;

  mag_t              run_mag;
  logic [ADDR_W-1:0] run_bin;
  logic              s3_last;
  mag_t              base_mag;
  logic [ADDR_W-1:0] base_bin;
  logic              take;
  logic              report_now;

  assign res_word = res_data;

  // Bin index of the incoming word; frame_start forces it to bin 0.
  always_comb begin
    cur_bin      = frame_start ? '0 : bin_cnt;
    last_bin     = (cur_bin == LAST_BIN);
    next_bin     = last_bin ? '0 : cur_bin + ADDR_W'(1);
    frame_active = res_valid || (bin_cnt != '0);
  end

  // Bin counter: advances per accepted word, wraps after the last bin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_cnt <= '0;
    end else if (res_valid) begin
      bin_cnt <= next_bin;
    end else if (frame_start) begin
      bin_cnt <= '0;
    end
  end

  // Passthrough to the output RAM write port, one cycle of latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fft_write_en   <= 1'b0;
      fft_write_addr <= '0;
      data_from_fft  <= '0;
    end else begin
      fft_write_en   <= res_valid;
      fft_write_addr <= cur_bin;
      data_from_fft  <= res_data;
    end
  end

  fft_mag_est #(
    .ADDR_W (ADDR_W)
  ) u_mag_est (
    .clk       (clk),
    .reset     (reset),
    .flush     (frame_start),
    .in_valid  (res_valid),
    .in_data   (res_word),
    .in_bin    (cur_bin),
    .out_valid (est_valid),
    .out_bin   (est_bin),
    .out_mag   (est_mag)
  );

  // Stage 3 compare: once the last bin has landed, the running peak is handed
  // to the report registers and the next frame compares against a clean slate.
  always_comb begin
    base_mag   = s3_last ? '0 : run_mag;
    base_bin   = s3_last ? '0 : run_bin;
    take       = est_valid && (est_bin >= LO_BIN) && (est_bin <= HI_BIN) &&
                 (est_mag > base_mag);
    report_now = s3_last && !frame_start;
  end

  // Stage 3 update: strict '>' keeps the lowest bin on a tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_mag <= '0;
      run_bin <= '0;
      s3_last <= 1'b0;
    end else if (frame_start) begin
      run_mag <= '0;
      run_bin <= '0;
      s3_last <= 1'b0;
    end else begin
      run_mag <= take ? est_mag : base_mag;
      run_bin <= take ? est_bin : base_bin;
      s3_last <= est_valid && (est_bin == LAST_BIN);
    end
  end

  // Report registers hold until the next completed frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_bin   <= '0;
      peak_mag   <= '0;
      peak_found <= 1'b0;
    end else if (report_now) begin
      peak_bin   <= run_bin;
      peak_mag   <= run_mag;
      peak_found <= (run_mag >= THRESH);
    end
  end

  // Frame FSM: sequences scan, drain and report, and drives busy/peak_valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      peak_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      peak_valid <= 1'b0;
      if (frame_start) begin
        state <= res_valid ? SCAN : IDLE;
        busy  <= res_valid;
      end else begin
        if (res_valid) begin
          busy <= 1'b1;
        end
        case (state)
          IDLE: begin
            if (res_valid) begin
              state <= last_bin ? FLUSH : SCAN;
            end
          end
          SCAN: begin
            if (res_valid && last_bin) begin
              state <= FLUSH;
            end
          end
          FLUSH: begin
            if (report_now) begin
              state      <= REPORT;
              peak_valid <= 1'b1;
              busy       <= frame_active;
            end
          end
          REPORT: begin
            state <= frame_active ? SCAN : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: expected RAM writes and frame reports
// are queued as stimulus is driven and popped as the design produces them.
module tb_fft_peak_detect;

  logic        clk;
  logic        reset;
  logic        frame_start;
  logic        res_valid;
  logic [31:0] res_data;
  logic        fft_write_en;
  logic [8:0]  fft_write_addr;
  logic [31:0] data_from_fft;
  logic        peak_valid;
  logic        peak_found;
  logic [8:0]  peak_bin;
  logic [15:0] peak_mag;
  logic        busy;

  fft_peak_detect dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .res_valid      (res_valid),
    .res_data       (res_data),
    .fft_write_en   (fft_write_en),
    .fft_write_addr (fft_write_addr),
    .data_from_fft  (data_from_fft),
    .peak_valid     (peak_valid),
    .peak_found     (peak_found),
    .peak_bin       (peak_bin),
    .peak_mag       (peak_mag),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  typedef struct {
    int unsigned cyc;
    logic [8:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int unsigned cyc;
    logic [8:0]  bin;
    logic [15:0] mag;
    logic        found;
    logic        busy;
  } rpt_exp_t;

  wr_exp_t     wr_q[$];
  rpt_exp_t    rpt_q[$];
  int unsigned pv_cyc[$];
  int          n_writes = 0;

  // Reference model state.
  int          m_bin = 0;
  int unsigned m_best = 0;
  int          m_best_bin = 0;
  logic        exp_busy_next = 1'b0;
  logic [31:0] frame_buf [512];

  function automatic int unsigned model_mag(input logic [31:0] w);
    int re, im, a, b;
    re = $signed(w[31:16]);
    im = $signed(w[15:0]);
    a  = (re < 0) ? -re : re;
    b  = (im < 0) ? -im : im;
    if (a >= b) return a + b / 2;
    return b + a / 2;
  endfunction

  // Output monitor, sampled away from the active edge.
  wr_exp_t  mon_w;
  rpt_exp_t mon_r;
  always @(negedge clk) begin
    if (reset) begin
      if (fft_write_en) begin
        n_writes++;
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          mon_w = wr_q.pop_front();
          check("wr_addr_data", {fft_write_addr, data_from_fft}, {mon_w.addr, mon_w.data});
          check("wr_cycle", cyc, mon_w.cyc);
        end
      end
      if (peak_valid) begin
        pv_cyc.push_back(cyc);
        if (rpt_q.size() == 0) check("peak_unexpected", 1, 0);
        else begin
          mon_r = rpt_q.pop_front();
          check("rpt_cycle", cyc, mon_r.cyc);
          check("rpt_bin", peak_bin, mon_r.bin);
          check("rpt_mag", peak_mag, mon_r.mag);
          check("rpt_found", peak_found, mon_r.found);
          check("rpt_busy", busy, mon_r.busy);
        end
      end
    end
  end

  task automatic model_clear();
    m_bin      = 0;
    m_best     = 0;
    m_best_bin = 0;
  endtask

  // Drives one word; entered and left #1 after a rising edge.
  task automatic drive_word(input logic [31:0] w, input logic fs);
    wr_exp_t     e;
    rpt_exp_t    r;
    int unsigned mag;
    frame_start = fs;
    res_valid   = 1'b1;
    res_data    = w;
    if (fs) model_clear();
    e.cyc  = cyc + 1;
    e.addr = m_bin[8:0];
    e.data = w;
    wr_q.push_back(e);
    mag = model_mag(w);
    if (m_bin >= 1 && m_bin <= 255 && mag > m_best) begin
      m_best     = mag;
      m_best_bin = m_bin;
    end
    if (m_bin == 511) begin
      r.cyc   = cyc + 4;
      r.bin   = m_best_bin[8:0];
      r.mag   = m_best[15:0];
      r.found = (m_best >= 64);
      r.busy  = exp_busy_next;
      rpt_q.push_back(r);
      model_clear();
    end else begin
      m_bin++;
    end
    @(posedge clk); #1;
    frame_start = 1'b0;
    res_valid   = 1'b0;
  endtask

  task automatic drive_frame(input logic fs_first, input int nbins, input logic gaps);
    for (int i = 0; i < nbins; i++) begin
      drive_word(frame_buf[i], fs_first && (i == 0));
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic fill(input logic [31:0] w);
    for (int i = 0; i < 512; i++) frame_buf[i] = w;
  endtask

  // Bounded wait for every queued expectation to be consumed.
  task automatic wait_drain();
    int n = 0;
    while ((wr_q.size() != 0 || rpt_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
    check("drain_wr", wr_q.size(), 0);
    check("drain_rpt", rpt_q.size(), 0);
    wr_q.delete();
    rpt_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_wr"}, {fft_write_en, fft_write_addr, data_from_fft}, 0);
    check({tag, "_peak"}, {peak_valid, peak_found, peak_bin, peak_mag, busy}, 0);
  endtask

  task automatic check_held(input logic [8:0] b, input logic [15:0] m, input logic f);
    check("held_bin", peak_bin, b);
    check("held_mag", peak_mag, m);
    check("held_found", peak_found, f);
  endtask

  int w0;
  int p0;

  initial begin
    reset       = 1'b0;
    frame_start = 1'b0;
    res_valid   = 1'b0;
    res_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Single tone at bin 37.
    check("idle_busy", busy, 0);
    fill(32'h0);
    frame_buf[37] = 32'h2000_1000;
    exp_busy_next = 1'b0;
    w0 = n_writes;
    p0 = pv_cyc.size();
    drive_frame(1'b1, 512, 1'b0);
    wait_drain();
    check("tone_writes", n_writes - w0, 512);
    check("tone_pulses", pv_cyc.size() - p0, 1);
    check_held(9'd37, 16'h2800, 1'b1);
    check("tone_busy_after", busy, 0);

    // Out-of-band bins and a tie between bins 10 and 20.
    fill(32'h0);
    frame_buf[0]   = 32'h7FFF_0000;
    frame_buf[300] = 32'h4000_0000;
    frame_buf[10]  = 32'h0100_0000;
    frame_buf[20]  = 32'h0100_0000;
    drive_frame(1'b1, 512, 1'b0);
    wait_drain();
    check_held(9'd10, 16'h0100, 1'b1);

    // Below threshold everywhere, with random input gaps.
    fill(32'h0020_0010);
    drive_frame(1'b1, 512, 1'b1);
    wait_drain();
    check_held(9'd1, 16'h0028, 1'b0);

    // Most negative value on both components.
    fill(32'h0);
    frame_buf[5] = 32'h8000_8000;
    drive_frame(1'b1, 512, 1'b0);
    wait_drain();
    check_held(9'd5, 16'd49152, 1'b1);

    // Abort after 200 bins; frame_start coincides with the next word.
    fill(32'h0);
    frame_buf[150] = 32'h7000_0000;
    p0 = pv_cyc.size();
    drive_frame(1'b1, 200, 1'b0);
    fill(32'h0);
    frame_buf[20] = 32'h1000_0000;
    drive_frame(1'b1, 512, 1'b0);
    wait_drain();
    check("abort_pulses", pv_cyc.size() - p0, 1);
    check_held(9'd20, 16'h1000, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    fill(32'h0);
    frame_buf[77] = 32'h0000_3000;
    drive_frame(1'b1, 100, 1'b0);
    @(negedge clk); #1;
    check("mid_busy", busy, 1);
    reset = 1'b0;
    #1;
    check_zero("mid_reset");
    model_clear();
    wr_q.delete();
    rpt_q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    drive_frame(1'b1, 512, 1'b0);
    wait_drain();
    check_held(9'd77, 16'h3000, 1'b1);

    // Two frames back to back; the second starts by wrap-around.
    fill(32'h0);
    frame_buf[40] = 32'h0000_0500;
    p0 = pv_cyc.size();
    exp_busy_next = 1'b1;
    drive_frame(1'b1, 512, 1'b0);
    fill(32'h0);
    frame_buf[200] = 32'h0600_0600;
    exp_busy_next = 1'b0;
    drive_frame(1'b0, 512, 1'b0);
    wait_drain();
    check("b2b_pulses", pv_cyc.size() - p0, 2);
    if (pv_cyc.size() - p0 == 2)
      check("b2b_spacing", pv_cyc[p0 + 1] - pv_cyc[p0], 512);
    check_held(9'd200, 16'h0900, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
